// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin front end sharing one fixed-latency CORDIC core
// between NUM_REQ requesters. Results are tagged, buffered in a result FIFO,
// and a credit counter keeps the non-stallable core from overflowing it.
// Ports:
//   clk, rst_n                  clock, async active-low reset (also resets core)
//   req_valid/req_ready         per-requester handshake (req_ready combinational)
//   req_mode, req_x/y/z         per-requester mode and flattened operands
//   core_valid_in, core_mode,
//   core_x/y/z                  registered core inputs
//   core_valid_out, core_cos,
//   core_sin, core_tan_in       core outputs
//   rsp_valid/rsp_ready         result handshake
//   rsp_id, rsp_mode, rsp_cos,
//   rsp_sin, rsp_atan           FIFO head tag and payload
//   busy                        credits in use
//   err                         sticky tag misalignment / overflow flag
module cordic_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned LATENCY    = 13,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_mode,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  input  logic [NUM_REQ*WIDTH-1:0] req_z,
  output logic                     core_valid_in,
  output logic                     core_mode,
  output logic [WIDTH-1:0]         core_x,
  output logic [WIDTH-1:0]         core_y,
  output logic [WIDTH-1:0]         core_z,
  input  logic                     core_valid_out,
  input  logic [WIDTH-1:0]         core_cos,
  input  logic [WIDTH-1:0]         core_sin,
  input  logic [WIDTH-1:0]         core_tan_in,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic                     rsp_mode,
  output logic [WIDTH-1:0]         rsp_cos,
  output logic [WIDTH-1:0]         rsp_sin,
  output logic [WIDTH-1:0]         rsp_atan,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic             mode;
    logic [WIDTH-1:0] cos;
    logic [WIDTH-1:0] sin;
    logic [WIDTH-1:0] atan;
  } rsp_t;

  logic [CW-1:0]    used_q, used_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   win_c, idx_c;
  logic             any_c, grant_c, pop_c, push_c, ovf_c, mis_c;
  logic             vld_q, mode_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] x_q, y_q, z_q;
  logic             tag_vld_q  [LATENCY];
  logic [IDW-1:0]   tag_id_q   [LATENCY];
  logic             tag_mode_q [LATENCY];
  rsp_t             mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q;

  // Round-robin scan starting at ptr_q, first valid requester wins
  always_comb begin
    win_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_c = IDW'((32'(ptr_q) + k) % NUM_REQ);
      if (!any_c && req_valid[idx_c]) begin
        any_c = 1'b1;
        win_c = idx_c;
      end
    end
  end

  // rst_n gating keeps req_ready low while reset is held
  assign grant_c = any_c && (used_q < CW'(FIFO_DEPTH)) && rst_n;

  always_comb begin
    req_ready = '0;
    if (grant_c) req_ready[win_c] = 1'b1;
  end

  assign rsp_valid = (cnt_q != '0);
  assign pop_c     = rsp_valid && rsp_ready;
  // Pop frees a slot in the same cycle, so push at full is legal with a pop
  assign push_c    = core_valid_out && ((cnt_q < CW'(FIFO_DEPTH)) || pop_c);
  assign ovf_c     = core_valid_out && (cnt_q == CW'(FIFO_DEPTH)) && !pop_c;
  assign mis_c     = core_valid_out != tag_vld_q[LATENCY-1];

  // Credit, pointer and occupancy next-state
  always_comb begin
    used_d = used_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    if (grant_c && !pop_c) used_d = used_q + CW'(1);
    if (!grant_c && pop_c) used_d = used_q - CW'(1);
    if (grant_c) ptr_d = (win_c == IDW'(NUM_REQ - 1)) ? '0 : win_c + IDW'(1);
    if (push_c && !pop_c) cnt_d = cnt_q + CW'(1);
    if (!push_c && pop_c) cnt_d = cnt_q - CW'(1);
  end

  // Control state and issue register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used_q <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      vld_q  <= 1'b0;
      mode_q <= 1'b0;
      id_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
    end else begin
      used_q <= used_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_q | mis_c | ovf_c;
      vld_q  <= grant_c;
      if (grant_c) begin
        mode_q <= req_mode[win_c];
        id_q   <= win_c;
        x_q    <= req_x[32'(win_c)*WIDTH +: WIDTH];
        y_q    <= req_y[32'(win_c)*WIDTH +: WIDTH];
        z_q    <= req_z[32'(win_c)*WIDTH +: WIDTH];
      end
    end
  end

  // Tag pipe follows the issue register so its last stage meets core_valid_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tag_vld_q[i]  <= 1'b0;
        tag_id_q[i]   <= '0;
        tag_mode_q[i] <= 1'b0;
      end
    end else begin
      tag_vld_q[0]  <= vld_q;
      tag_id_q[0]   <= id_q;
      tag_mode_q[0] <= mode_q;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_id_q[i]   <= tag_id_q[i-1];
        tag_mode_q[i] <= tag_mode_q[i-1];
      end
    end
  end

  // Result FIFO storage; cleared on reset so the head reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_c) begin
        mem_q[wr_q] <= '{id: tag_id_q[LATENCY-1], mode: tag_mode_q[LATENCY-1],
                         cos: core_cos, sin: core_sin, atan: core_tan_in};
        wr_q <= (wr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_q + AW'(1);
      end
      if (pop_c) rd_q <= (rd_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_q + AW'(1);
    end
  end

  assign core_valid_in = vld_q;
  assign core_mode     = mode_q;
  assign core_x        = x_q;
  assign core_y        = y_q;
  assign core_z        = z_q;
  assign rsp_id        = mem_q[rd_q].id;
  assign rsp_mode      = mem_q[rd_q].mode;
  assign rsp_cos       = mem_q[rd_q].cos;
  assign rsp_sin       = mem_q[rd_q].sin;
  assign rsp_atan      = mem_q[rd_q].atan;
  assign busy          = (used_q != '0);
  assign err           = err_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: bench for cordic_arbiter with a behavioural core model,
// a transaction-level reference model, table vectors and directed sequences.
module tb_cordic_arbiter;
  localparam int unsigned NR  = 4;
  localparam int unsigned W   = 32;
  localparam int unsigned L   = 13;
  localparam int unsigned D   = 16;
  localparam int unsigned IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b1;
  logic [NR-1:0]   req_valid = '0, req_ready, req_mode = '0;
  logic [NR*W-1:0] req_x = '0, req_y = '0, req_z = '0;
  logic            core_valid_in, core_mode;
  logic [W-1:0]    core_x, core_y, core_z;
  logic            core_valid_out;
  logic [W-1:0]    core_cos, core_sin, core_tan_in;
  logic            rsp_valid, rsp_ready = 1'b0;
  logic [IDW-1:0]  rsp_id;
  logic            rsp_mode;
  logic [W-1:0]    rsp_cos, rsp_sin, rsp_atan;
  logic            busy, err;

  cordic_arbiter #(.NUM_REQ(NR), .WIDTH(W), .LATENCY(L), .FIFO_DEPTH(D), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .core_valid_in(core_valid_in), .core_mode(core_mode),
    .core_x(core_x), .core_y(core_y), .core_z(core_z),
    .core_valid_out(core_valid_out), .core_cos(core_cos), .core_sin(core_sin),
    .core_tan_in(core_tan_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_mode(rsp_mode),
    .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .rsp_atan(rsp_atan),
    .busy(busy), .err(err)
  );

  function automatic logic [W-1:0] f_cos(input logic [W-1:0] z);
    return z + 32'h1234_5678;
  endfunction
  function automatic logic [W-1:0] f_sin(input logic [W-1:0] z);
    return z ^ 32'hA5A5_A5A5;
  endfunction
  function automatic logic [W-1:0] f_atan(input logic [W-1:0] x, input logic [W-1:0] y);
    return x - y;
  endfunction

  // Stand-in core: fixed latency L, zeroes the unused outputs per mode
  logic         cm_v [L];
  logic [W-1:0] cm_c [L], cm_s [L], cm_a [L];
  logic         inj = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) cm_v[i] <= 1'b0;
    end else begin
      cm_v[0] <= core_valid_in;
      cm_c[0] <= core_mode ? f_cos(core_z) : '0;
      cm_s[0] <= core_mode ? f_sin(core_z) : '0;
      cm_a[0] <= core_mode ? '0 : f_atan(core_x, core_y);
      for (int i = 1; i < L; i++) begin
        cm_v[i] <= cm_v[i-1];
        cm_c[i] <= cm_c[i-1];
        cm_s[i] <= cm_s[i-1];
        cm_a[i] <= cm_a[i-1];
      end
    end
  end
  assign core_valid_out = cm_v[L-1] | inj;
  assign core_cos       = cm_c[L-1];
  assign core_sin       = cm_s[L-1];
  assign core_tan_in    = cm_a[L-1];

  typedef struct {
    int           id;
    bit           mode;
    logic [W-1:0] c, s, a;
    int           avail;
  } exp_t;

  exp_t q[$];
  int   m_ptr = 0, m_used = 0, cyc = 0;
  int   n_chk = 0, n_err = 0;
  logic [NR-1:0] last_rdy;

  typedef struct {
    logic [NR-1:0] v;
    logic [NR-1:0] exp_rdy;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      req_x[i*W +: W] = $urandom();
      req_y[i*W +: W] = $urandom();
      req_z[i*W +: W] = $urandom();
      req_mode[i]     = 1'($urandom());
    end
  endtask

  task automatic chk_reset();
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_core_valid_in", core_valid_in, 0);
    chk("rst_core_mode", core_mode, 0);
    chk("rst_core_x", core_x, 0);
    chk("rst_core_y", core_y, 0);
    chk("rst_core_z", core_z, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_mode", rsp_mode, 0);
    chk("rst_rsp_cos", rsp_cos, 0);
    chk("rst_rsp_sin", rsp_sin, 0);
    chk("rst_rsp_atan", rsp_atan, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
  endtask

  // Asserts reset off the clock edge, checks outputs asynchronously, clears model
  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '1;
    inj = 1'b0;
    #1;
    chk_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    q.delete();
    m_ptr = 0;
    m_used = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: drive, compare against the model, advance model and clock
  task automatic step(input logic [NR-1:0] v, input logic rr, output int gnt);
    int           win;
    logic [NR-1:0] er;
    bit           erv;
    exp_t         e;
    logic [W-1:0] x, y, z;
    req_valid = v;
    rsp_ready = rr;
    #1;
    win = -1;
    if (m_used < D)
      for (int k = 0; k < NR; k++)
        if (win < 0 && v[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
    er = '0;
    if (win >= 0) er[win] = 1'b1;
    last_rdy = req_ready;
    chk("req_ready", 64'(req_ready), 64'(er));
    erv = (q.size() > 0) && (q[0].avail <= cyc);
    chk("rsp_valid", rsp_valid, erv);
    if (erv) begin
      chk("rsp_id", rsp_id, q[0].id);
      chk("rsp_mode", rsp_mode, q[0].mode);
      chk("rsp_cos", rsp_cos, q[0].c);
      chk("rsp_sin", rsp_sin, q[0].s);
      chk("rsp_atan", rsp_atan, q[0].a);
    end
    chk("busy", busy, m_used != 0);
    chk("err", err, 0);
    if (win >= 0) begin
      x = req_x[win*W +: W];
      y = req_y[win*W +: W];
      z = req_z[win*W +: W];
      e.id    = win;
      e.mode  = req_mode[win];
      e.c     = e.mode ? f_cos(z) : '0;
      e.s     = e.mode ? f_sin(z) : '0;
      e.a     = e.mode ? '0 : f_atan(x, y);
      e.avail = cyc + L + 2;
      q.push_back(e);
      m_ptr = (win + 1) % NR;
      m_used++;
    end
    if (erv && rr) begin
      void'(q.pop_front());
      m_used--;
    end
    gnt = win;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int b = 0;
    int g;
    while (q.size() > 0 && b < 100) begin
      step('0, 1'b1, g);
      b++;
    end
    chk("drain_done", q.size(), 0);
  endtask

  initial begin
    int g, n, ng, exp_id, b;
    tbl[0] = '{4'b0000, 4'b0000};
    tbl[1] = '{4'b0100, 4'b0100};
    tbl[2] = '{4'b0101, 4'b0001};
    tbl[3] = '{4'b0101, 4'b0100};
    tbl[4] = '{4'b1111, 4'b1000};
    tbl[5] = '{4'b1111, 4'b0001};
    tbl[6] = '{4'b0011, 4'b0010};
    tbl[7] = '{4'b0011, 4'b0001};
    tbl[8] = '{4'b0000, 4'b0000};
    tbl[9] = '{4'b1000, 4'b1000};

    #2;
    do_reset();

    // Table: grant pattern from reset
    for (int i = 0; i < 10; i++) begin
      rand_ops();
      step(tbl[i].v, 1'b1, g);
      chk("tbl_ready", 64'(last_rdy), 64'(tbl[i].exp_rdy));
    end
    drain();

    // Single request, requester 2, sin/cos of zero
    do_reset();
    req_mode[2] = 1'b1;
    req_z[2*W +: W] = '0;
    step(4'b0100, 1'b1, g);
    chk("single_gnt", g, 2);
    chk("single_core_vin", core_valid_in, 1);
    chk("single_core_mode", core_mode, 1);
    n = 1;
    while (!rsp_valid && n < 40) begin
      step('0, 1'b1, g);
      n++;
    end
    chk("single_latency", n, 15);
    chk("single_rsp_id", rsp_id, 2);
    chk("single_rsp_mode", rsp_mode, 1);
    chk("single_rsp_cos", rsp_cos, 32'h1234_5678);
    chk("single_rsp_sin", rsp_sin, 32'hA5A5_A5A5);
    chk("single_rsp_atan", rsp_atan, 0);
    step('0, 1'b1, g);
    chk("single_busy_after", busy, 0);

    // All requesters continuously from reset
    do_reset();
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      step('1, 1'b1, g);
      chk("rr_order", g, k % NR);
    end
    exp_id = 0;
    b = 0;
    while (q.size() > 0 && b < 60) begin
      if (rsp_valid) begin
        chk("rr_rsp_id", rsp_id, exp_id % NR);
        exp_id++;
      end
      step('0, 1'b1, g);
      b++;
    end
    chk("rr_rsp_count", exp_id, 8);

    // Back-pressure: credit limit, then one pop frees exactly one grant
    do_reset();
    ng = 0;
    for (int k = 0; k < 30; k++) begin
      rand_ops();
      step('1, 1'b0, g);
      if (g >= 0) ng++;
    end
    chk("bp_grants", ng, 16);
    chk("bp_ready_low", 64'(last_rdy), 0);
    step('1, 1'b1, g);
    chk("bp_pop_cycle", g >= 0, 0);
    step('1, 1'b0, g);
    chk("bp_one_more", g >= 0, 1);
    ng = 0;
    for (int k = 0; k < 5; k++) begin
      step('1, 1'b0, g);
      if (g >= 0) ng++;
    end
    chk("bp_no_more", ng, 0);
    drain();

    // rsp_ready toggling every cycle under full request load
    do_reset();
    for (int k = 0; k < 200; k++) begin
      rand_ops();
      step('1, 1'(k % 2), g);
    end
    drain();
    chk("toggle_err", err, 0);

    // Random traffic against the reference model
    do_reset();
    for (int k = 0; k < 500; k++) begin
      rand_ops();
      step(NR'($urandom()), ($urandom() % 4) != 0, g);
    end
    drain();
    chk("rand_empty", rsp_valid, 0);

    // Reset with 5 ops in the core and 3 in the FIFO
    do_reset();
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      step('1, 1'b0, g);
    end
    b = 0;
    while (!(q.size() >= 3 && q[2].avail <= cyc) && b < 40) begin
      step('0, 1'b0, g);
      b++;
    end
    chk("midrst_fifo3", rsp_valid, 1);
    chk("midrst_count", q.size(), 8);
    do_reset();
    for (int k = 0; k < 30; k++) step('0, 1'b1, g);

    // Misalignment: core valid with no tag in flight
    do_reset();
    inj = 1'b1;
    #1;
    chk("inj_pre", err, 0);
    @(posedge clk);
    #1;
    inj = 1'b0;
    chk("inj_set", err, 1);
    repeat (5) @(negedge clk);
    chk("inj_sticky", err, 1);
    do_reset();
    @(negedge clk);
    chk("inj_cleared", err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Round-robin front end that shares one `cordic_pipleine` core (fixed latency, no stall input) between `NUM_REQ` requesters. It accepts at most one operation per cycle over per-requester valid/ready handshakes and drives the core's input side from registers. It tags every issued operation with its requester ID and mode. Results are returned through a shared result FIFO with valid/ready back-pressure, and a credit counter guarantees the non-stallable core can never overflow that FIFO.

## Interface
- `NUM_REQ`, 4: number of requesters, at least 2.
- `WIDTH`, 32: data width; must match the core.
- `LATENCY`, 13: cycles from core `valid_in` to core `valid_out`; equals the core's `NUM_STAGES`.
- `FIFO_DEPTH`, 16: result FIFO entries; also the credit limit; at least 2.
- `IDW`, `max(1, $clog2(NUM_REQ))`: requester ID width.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low; the same net resets the core.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_ready` out NUM_REQ: per-requester grant (combinational).
- `req_mode` in NUM_REQ: 0 = arctan (x,y); 1 = sin/cos (z).
- `req_x`, `req_y`, `req_z` in NUM_REQ*WIDTH: flattened operands; requester i occupies bits [i*WIDTH +: WIDTH].
- `core_valid_in` out 1, `core_mode` out 1, `core_x`/`core_y`/`core_z` out WIDTH: registered core inputs.
- `core_valid_out` in 1; `core_cos`, `core_sin`, `core_tan_in` in WIDTH: core outputs.
- `rsp_valid` out 1, `rsp_ready` in 1: result handshake.
- `rsp_id` out IDW, `rsp_mode` out 1: tag of the result at the FIFO head.
- `rsp_cos`, `rsp_sin`, `rsp_atan` out WIDTH: result payload at the FIFO head.
- `busy` out 1: high when credits in use are non-zero.
- `err` out 1: sticky tag/valid misalignment flag.

## Operation
- **Credit counter `used`** (0..FIFO_DEPTH): counts operations in flight plus FIFO entries.
  - +1 on issue; −1 on `rsp_valid && rsp_ready`; unchanged when both occur in one cycle.
  - `can_issue = (used < FIFO_DEPTH)`.
- **Arbitration** (combinational):
  - Scan from pointer `ptr` upward with wrap-around; the first i with `req_valid[i]` wins.
  - `req_ready[i] = can_issue && (i == winner)`; at most one bit is high.
  - `req_ready` never depends on `rsp_ready`.
- **Pointer update**:
  - On a grant to i, `ptr <= (i+1) mod NUM_REQ`.
  - With no grant, `ptr` holds.
  - Result: any continuously requesting requester is served within NUM_REQ grants.
- **Issue register**:
  - On a grant, next cycle `core_valid_in = 1` and `core_mode`/`core_x`/`core_y`/`core_z` carry the winner's operands.
  - With no grant, next cycle `core_valid_in = 0`; the data registers hold.
- **Tag shift register**:
  - LATENCY stages of {vld, id, mode}, loaded alongside the issue register.
  - The tag reaching the end aligns with the `core_valid_out` cycle.
- **Result FIFO**:
  - On `core_valid_out`, write {tag id, tag mode, cos, sin, tan_in}.
  - For mode 0, the stored cos/sin are zero; for mode 1, atan is zero. This is as the core drives them; no masking is added.
  - Pop on `rsp_valid && rsp_ready`.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - Data is first-in first-out, so results return in global issue order.
- **Overflow**: the credit counter makes FIFO overflow impossible. A push when full sets `err`, and the entry is dropped.
- **Error flag `err`**:
  - Set when `core_valid_out` differs from the tag vld at the end of the shift register.
  - Also set on the FIFO-full push above.
  - Cleared only by reset.
- **Reset state**:
  - Outputs: `req_ready = 0`, `core_valid_in = 0`, core data = 0, `rsp_valid = 0`, `rsp_id`/`rsp_mode`/`rsp_cos`/`rsp_sin`/`rsp_atan` = 0, `busy = 0`, `err = 0`.
  - Internal: `ptr = 0`, `used = 0`, tag pipe vld all 0, FIFO empty.
  - Asserting reset mid-operation discards all in-flight and buffered results; the core is reset together with the arbiter.

## Timing
- Request handshake in cycle N → `core_valid_in` high in N+1 → `core_valid_out` in N+1+LATENCY → FIFO write at the end of that cycle → `rsp_valid` in N+2+LATENCY. The minimum request-to-response latency is LATENCY+2 = 15 cycles.
- Sustained throughput is one operation per cycle while `rsp_ready = 1`.
- With `rsp_ready = 0`, issues stop after FIFO_DEPTH accepted operations.
- After one pop, `used` decrements and one new grant becomes possible in the next cycle.
- `rsp_*` are FIFO head registers: stable while `rsp_valid && !rsp_ready`.

## Test plan
- **Single request**:
  - Stimulus: requester 2, mode 1, z = 0, everyone else idle, `rsp_ready = 1`.
  - Required: `req_ready[2]` high the same cycle; `core_valid_in` one cycle later; `rsp_valid` 15 cycles after the handshake with `rsp_id = 2`, `rsp_mode = 1`; `busy` returns to 0 after the pop.
- **All requesters from reset**:
  - Stimulus: all four `req_valid` high continuously.
  - Required: grants in order 0,1,2,3,0,…; responses return as ids 0,1,2,3 in consecutive cycles.
- **Back-pressure**:
  - Stimulus: `rsp_ready = 0`, all requesters valid.
  - Required: exactly 16 grants, then `req_ready = 0` indefinitely and `rsp_*` stable. Raising `rsp_ready` for one cycle yields exactly one further grant, in the following cycle.
- **Simultaneous issue and pop at full credit**:
  - Stimulus: `rsp_ready` toggling every cycle.
  - Required: `used` never exceeds 16; no result is lost or duplicated; `err` stays 0.
- **Reset mid-flight**:
  - Stimulus: assert `rst_n = 0` with 5 operations in the pipe and 3 in the FIFO.
  - Required: all outputs reach their reset values asynchronously; no `rsp_valid` appears afterwards until a new request is made.
- **Misalignment injection**:
  - Stimulus: force `core_valid_out` high with no tag in flight.
  - Required: `err` rises on the next edge and stays high until reset.
